// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: start/halt/branch controls, PC counter hooks,
// instruction memory port and the decode-side instruction handshake.
interface pc_fetch_ctrl_if;
    logic        start;
    logic        halt_req;
    logic        br_valid;
    logic [15:0] br_target;
    logic [15:0] pc_val;
    logic        pc_load;
    logic        pc_en;
    logic [15:0] pc_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  start, halt_req, br_valid, br_target, pc_val,
        input  imem_ack, imem_rdata, instr_ready,
        output pc_load, pc_en, pc_target, imem_req, imem_addr,
        output instr_valid, instr, instr_pc
    );

    modport slave (
        output start, halt_req, br_valid, br_target, pc_val,
        output imem_ack, imem_rdata, instr_ready,
        input  pc_load, pc_en, pc_target, imem_req, imem_addr,
        input  instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: drives the external PC counter, issues instruction
// memory requests and buffers one instruction for decode.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        FETCH,
        HOLD,
        HALT
    } state_e;

    state_e      state_q, state_d;
    logic        halt_q, halt_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;
    logic        load_c;
    logic        en_c;
    logic        req_c;
    logic [15:0] target_c;
    logic        halt_now;

    assign halt_now = halt_q | bus.halt_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            halt_q  <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halt_d   = halt_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        load_c   = 1'b0;
        en_c     = 1'b0;
        req_c    = 1'b0;
        target_c = RESET_VEC;
        unique case (state_q)
            INIT: begin
                load_c  = 1'b1;
                state_d = IDLE;
            end
            IDLE, HALT: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH, HOLD: begin
                if (bus.br_valid) begin
                    // Redirect wins; a coincident halt still stops fetching
                    load_c   = 1'b1;
                    target_c = bus.br_target;
                    state_d  = halt_now ? HALT : FETCH;
                    halt_d   = 1'b0;
                end else if (state_q == FETCH) begin
                    if (bus.imem_ack) begin
                        req_c   = 1'b1;
                        en_c    = 1'b1;
                        instr_d = bus.imem_rdata;
                        ipc_d   = bus.pc_val;
                        halt_d  = halt_now;
                        state_d = HOLD;
                    end else if (halt_now) begin
                        halt_d  = 1'b0;
                        state_d = HALT;
                    end else begin
                        req_c = 1'b1;
                    end
                end else begin
                    halt_d = halt_now;
                    if (bus.instr_ready) begin
                        state_d = halt_now ? HALT : FETCH;
                        if (halt_now) halt_d = 1'b0;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign bus.pc_load     = load_c & ~rst;
    assign bus.pc_en       = en_c;
    assign bus.pc_target   = target_c;
    assign bus.imem_req    = req_c;
    assign bus.imem_addr   = bus.pc_val;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
endmodule
